egr_rrq_arb: RTL and testbench

Parametrised egress read-request arbiter between NUM_REQ read requestors and the single mesh read interface (MRI). It buffers each requestor's read requests in a per-channel FIFO and picks one channel per cycle by round-robin. It stamps each issued request with a free tag from a pool of MAX_OUTSTANDING tags, and returns the tag to the pool when MRI reports the response complete. It supersedes the single-channel, untagged requestor-to-MRI connection.

---
 rtl/egr_rrq_arb.sv | 161 ++++++++++++++++
 tb/tb_egr_rrq_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/egr_rrq_arb.sv
// Round-robin read-request arbiter: per-channel FIFOs feed a single tagged
// mesh read interface, with a tag pool released by completed responses.
module egr_rrq_arb #(
    parameter int  NUM_REQ         = 4,
    parameter int  ADDR_W          = 20,
    parameter int  FIFO_DEPTH      = 4,
    parameter int  MAX_OUTSTANDING = 16,
    localparam int TAG_W           = $clog2(MAX_OUTSTANDING),
    localparam int SRC_W           = $clog2(NUM_REQ),
    localparam int USE_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        rq_valid,
    output logic [NUM_REQ-1:0]        rq_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] rq_addr,
    output logic                      mri_req_valid,
    input  logic                      mri_req_ready,
    output logic [ADDR_W-1:0]         mri_req_addr,
    output logic [SRC_W-1:0]          mri_req_src,
    output logic [TAG_W-1:0]          mri_req_tag,
    input  logic                      mri_rsp_valid,
    input  logic [TAG_W-1:0]          mri_rsp_tag,
    output logic [USE_W-1:0]          tags_in_use,
    output logic                      err_bad_tag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0]          mem    [NUM_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr [NUM_REQ];
    logic [PTR_W-1:0]           rd_ptr [NUM_REQ];
    logic [CNT_W-1:0]           cnt    [NUM_REQ];
    logic [NUM_REQ-1:0]         nonempty, push, pop;

    logic [SRC_W-1:0]           rr_ptr, arb_src, cand;
    logic                       arb_found;
    logic [MAX_OUTSTANDING-1:0] bitmap, bitmap_nxt;
    logic [TAG_W-1:0]           free_tag;
    logic                       free_found;

    logic                       lock_q;
    logic [SRC_W-1:0]           lock_src;
    logic [ADDR_W-1:0]          lock_addr;
    logic [TAG_W-1:0]           lock_tag;

    logic [SRC_W-1:0]           gnt_src;
    logic [ADDR_W-1:0]          gnt_addr;
    logic [TAG_W-1:0]           gnt_tag;
    logic                       req_vld, hs, rel_ok, rel_bad;

    // Ready comes only from the registered count; a same-cycle pop does not help.
    always_comb begin
        rq_ready = '0;
        nonempty = '0;
        push     = '0;
        pop      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_ready[i] = (cnt[i] != CNT_W'(FIFO_DEPTH));
            nonempty[i] = (cnt[i] != '0);
            push[i]     = rq_valid[i] && rq_ready[i];
            pop[i]      = hs && (gnt_src == SRC_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i])      cnt[i] <= cnt[i] + CNT_W'(1);
                else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= rq_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        arb_found = 1'b0;
        arb_src   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!arb_found && nonempty[cand]) begin
                arb_found = 1'b1;
                arb_src   = cand;
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_tag   = '0;
        for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            if (!free_found && !bitmap[k]) begin
                free_found = 1'b1;
                free_tag   = TAG_W'(k);
            end
        end
    end

    // A locked request keeps its tag free in the bitmap, so valid needs no free-tag term.
    assign gnt_src  = lock_q ? lock_src  : arb_src;
    assign gnt_addr = lock_q ? lock_addr : mem[arb_src][rd_ptr[arb_src]];
    assign gnt_tag  = lock_q ? lock_tag  : free_tag;
    assign req_vld  = lock_q || (arb_found && free_found);
    assign hs       = req_vld && mri_req_ready;

    assign mri_req_valid = req_vld;
    assign mri_req_addr  = req_vld ? gnt_addr : '0;
    assign mri_req_src   = req_vld ? gnt_src  : '0;
    assign mri_req_tag   = req_vld ? gnt_tag  : '0;

    always_comb begin
        bitmap_nxt = bitmap;
        rel_ok     = mri_rsp_valid && bitmap[mri_rsp_tag];
        rel_bad    = mri_rsp_valid && !bitmap[mri_rsp_tag];
        if (rel_ok) bitmap_nxt[mri_rsp_tag] = 1'b0;
        if (hs)     bitmap_nxt[gnt_tag]     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap      <= '0;
            rr_ptr      <= '0;
            lock_q      <= 1'b0;
            lock_src    <= '0;
            lock_addr   <= '0;
            lock_tag    <= '0;
            tags_in_use <= '0;
            err_bad_tag <= 1'b0;
        end else begin
            bitmap <= bitmap_nxt;
            if (hs && !rel_ok)      tags_in_use <= tags_in_use + USE_W'(1);
            else if (!hs && rel_ok) tags_in_use <= tags_in_use - USE_W'(1);
            if (rel_bad) err_bad_tag <= 1'b1;
            if (hs) begin
                rr_ptr <= (gnt_src == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_src + SRC_W'(1);
                lock_q <= 1'b0;
            end else if (req_vld) begin
                lock_q    <= 1'b1;
                lock_src  <= gnt_src;
                lock_addr <= gnt_addr;
                lock_tag  <= gnt_tag;
            end
        end
    end

endmodule

// File: tb/tb_egr_rrq_arb.sv
// Bench for egr_rrq_arb: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based behavioural model.
module tb_egr_rrq_arb;
    localparam int N = 4, AW = 20, DEPTH = 4, MAXO = 16, TW = 4, SW = 2, UW = 5;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]    rq_valid = '0, rq_ready;
    logic [N*AW-1:0] rq_addr = '0;
    logic            mri_req_valid, mri_req_ready = 1'b0;
    logic [AW-1:0]   mri_req_addr;
    logic [SW-1:0]   mri_req_src;
    logic [TW-1:0]   mri_req_tag, mri_rsp_tag = '0;
    logic            mri_rsp_valid = 1'b0;
    logic [UW-1:0]   tags_in_use;
    logic            err_bad_tag;

    always #5 clk = ~clk;

    egr_rrq_arb #(.NUM_REQ(N), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr),
        .mri_req_valid(mri_req_valid), .mri_req_ready(mri_req_ready), .mri_req_addr(mri_req_addr),
        .mri_req_src(mri_req_src), .mri_req_tag(mri_req_tag), .mri_rsp_valid(mri_rsp_valid),
        .mri_rsp_tag(mri_rsp_tag), .tags_in_use(tags_in_use), .err_bad_tag(err_bad_tag));

    int n_checks = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: one address queue per channel, a tag-in-use array,
    // the round-robin start channel and the held (locked) request.
    logic [AW-1:0] mq [N][$];
    bit            mused [MAXO];
    int            m_rr, l_src, l_tag;
    bit            m_lock, m_err;
    logic [AW-1:0] l_addr;
    bit            e_valid;
    int            e_src, e_tag;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_rdy;

    function automatic int m_use();
        int c = 0;
        for (int t = 0; t < MAXO; t++) c += int'(mused[t]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        for (int t = 0; t < MAXO; t++) mused[t] = 1'b0;
        m_rr = 0; m_lock = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_expect();
        int  fs = -1;
        bit  found = 1'b0;
        e_valid = 1'b0; e_src = 0; e_tag = 0; e_addr = '0;
        for (int i = 0; i < N; i++) e_rdy[i] = (mq[i].size() < DEPTH);
        if (m_lock) begin
            e_valid = 1'b1; e_src = l_src; e_addr = l_addr; e_tag = l_tag;
        end else begin
            for (int t = MAXO - 1; t >= 0; t--) if (!mused[t]) fs = t;
            for (int k = 0; k < N; k++) begin
                int c = (m_rr + k) % N;
                if (!found && mq[c].size() > 0) begin found = 1'b1; e_src = c; end
            end
            if (found && fs >= 0) begin
                e_valid = 1'b1; e_addr = mq[e_src][0]; e_tag = fs;
            end
        end
    endtask

    task automatic model_update(input logic [N-1:0] vld, input logic [N*AW-1:0] av,
                                input logic rdy, input logic rv, input int rt);
        bit acc [N];
        for (int i = 0; i < N; i++) acc[i] = vld[i] && (mq[i].size() < DEPTH);
        if (rv) begin
            if (mused[rt]) mused[rt] = 1'b0;
            else           m_err = 1'b1;
        end
        if (e_valid && rdy) begin
            void'(mq[e_src].pop_front());
            mused[e_tag] = 1'b1;
            m_rr = (e_src + 1) % N;
            m_lock = 1'b0;
        end else if (e_valid) begin
            m_lock = 1'b1; l_src = e_src; l_addr = e_addr; l_tag = e_tag;
        end
        for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(av[i*AW +: AW]);
    endtask

    // One clock: drive at the falling edge, compare before the rising edge, advance the model.
    task automatic cycle(input logic [N-1:0] vld, input logic [N*AW-1:0] av,
                         input logic rdy, input logic rv, input int rt);
        rq_valid = vld; rq_addr = av; mri_req_ready = rdy;
        mri_rsp_valid = rv; mri_rsp_tag = TW'(rt);
        #1;
        model_expect();
        chk("valid", mri_req_valid, e_valid);
        if (e_valid) begin
            chk("src", mri_req_src, e_src);
            chk("addr", mri_req_addr, e_addr);
            chk("tag", mri_req_tag, e_tag);
        end
        chk("rq_ready", rq_ready, e_rdy);
        chk("tags_in_use", tags_in_use, m_use());
        chk("err_bad_tag", err_bad_tag, m_err);
        @(posedge clk);
        model_update(vld, av, rdy, rv, rt);
        @(negedge clk);
    endtask

    function automatic logic [N*AW-1:0] mk(input logic [AW-1:0] base);
        logic [N*AW-1:0] r;
        for (int i = 0; i < N; i++) r[i*AW +: AW] = base + AW'(i);
        return r;
    endfunction

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_valid"}, mri_req_valid, 0);
        chk({nm, "_rq_ready"}, rq_ready, 4'hF);
        chk({nm, "_use"}, tags_in_use, 0);
        chk({nm, "_err"}, err_bad_tag, 0);
        chk({nm, "_addr"}, mri_req_addr, 0);
        chk({nm, "_src"}, mri_req_src, 0);
        chk({nm, "_tag"}, mri_req_tag, 0);
    endtask

    task automatic apply_reset();
        rq_valid = '0; mri_req_ready = 1'b0; mri_rsp_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] vld; logic [AW-1:0] base; logic rdy; logic rv; int rt;
        logic ev; int esrc; logic [AW-1:0] eaddr; int etag; int euse;
    } vec_t;
    vec_t tbl [15];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N*AW-1:0] av;
        int rt;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        //        vld      base       rdy rv rt  ev src addr      tag use
        tbl[0]  = '{4'b0100, 20'h00ABA, 1, 0, 0, 0, 0, 20'h0,     0, 0};
        tbl[1]  = '{4'b0000, 20'h0,     1, 0, 0, 1, 2, 20'h00ABC, 0, 0};
        tbl[2]  = '{4'b0000, 20'h0,     1, 0, 0, 0, 0, 20'h0,     0, 1};
        tbl[3]  = '{4'b1111, 20'h10000, 0, 0, 0, 0, 0, 20'h0,     0, 1};
        tbl[4]  = '{4'b1111, 20'h20000, 0, 0, 0, 1, 3, 20'h10003, 1, 1};
        tbl[5]  = '{4'b0000, 20'h0,     1, 0, 0, 1, 3, 20'h10003, 1, 1};
        tbl[6]  = '{4'b0000, 20'h0,     1, 0, 0, 1, 0, 20'h10000, 2, 2};
        tbl[7]  = '{4'b0000, 20'h0,     1, 0, 0, 1, 1, 20'h10001, 3, 3};
        tbl[8]  = '{4'b0000, 20'h0,     1, 0, 0, 1, 2, 20'h10002, 4, 4};
        tbl[9]  = '{4'b0000, 20'h0,     1, 0, 0, 1, 3, 20'h20003, 5, 5};
        tbl[10] = '{4'b0000, 20'h0,     1, 0, 0, 1, 0, 20'h20000, 6, 6};
        tbl[11] = '{4'b0000, 20'h0,     1, 0, 0, 1, 1, 20'h20001, 7, 7};
        tbl[12] = '{4'b0000, 20'h0,     1, 0, 0, 1, 2, 20'h20002, 8, 8};
        tbl[13] = '{4'b0000, 20'h0,     1, 1, 0, 0, 0, 20'h0,     0, 9};
        tbl[14] = '{4'b0000, 20'h0,     1, 0, 0, 0, 0, 20'h0,     0, 8};
        for (int r = 0; r < 15; r++) begin
            chk($sformatf("tbl%0d_valid", r), mri_req_valid, tbl[r].ev);
            if (tbl[r].ev) begin
                chk($sformatf("tbl%0d_src", r), mri_req_src, tbl[r].esrc);
                chk($sformatf("tbl%0d_addr", r), mri_req_addr, tbl[r].eaddr);
                chk($sformatf("tbl%0d_tag", r), mri_req_tag, tbl[r].etag);
            end
            chk($sformatf("tbl%0d_use", r), tags_in_use, tbl[r].euse);
            chk($sformatf("tbl%0d_rq_ready", r), rq_ready, 4'hF);
            cycle(tbl[r].vld, mk(tbl[r].base), tbl[r].rdy, tbl[r].rv, tbl[r].rt);
        end

        // Tag exhaustion, release of tag 5, alloc+release at 15, bad release.
        apply_reset();
        for (int k = 0; k < 20; k++) cycle(4'hF, mk(20'h30000 + AW'(k * 16)), 1, 0, 0);
        chk("exh_valid", mri_req_valid, 0);
        chk("exh_use", tags_in_use, 16);
        chk("exh_fifos_full", rq_ready, 4'h0);
        cycle(4'h0, '0, 1, 1, 5);
        chk("exh_resume_valid", mri_req_valid, 1);
        chk("exh_resume_tag", mri_req_tag, 5);
        cycle(4'h0, '0, 1, 0, 0);
        cycle(4'h0, '0, 0, 1, 3);
        chk("m1_use", tags_in_use, 15);
        cycle(4'h0, '0, 1, 1, 7);
        chk("simul_use", tags_in_use, 15);
        cycle(4'h0, '0, 0, 1, 9);
        cycle(4'h0, '0, 0, 1, 9);
        chk("bad_rel_err", err_bad_tag, 1);
        cycle(4'h0, '0, 0, 0, 0);
        chk("err_sticky", err_bad_tag, 1);

        // Asynchronous reset in the middle of a burst.
        cycle(4'hF, mk(20'h40000), 1, 0, 0);
        cycle(4'hF, mk(20'h40010), 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        model_reset();
        rq_valid = '0; mri_req_ready = 1'b0; mri_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'h0, '0, 0, 1, 2);
        chk("late_rel_err", err_bad_tag, 1);

        // FIFO full on channel 1 under backpressure.
        apply_reset();
        for (int k = 0; k < 4; k++) cycle(4'b0010, mk(20'h50000 + AW'(k * 16)), 0, 0, 0);
        chk("full_rdy1", rq_ready[1], 0);
        cycle(4'b0010, mk(20'h5F000), 0, 0, 0);
        cycle(4'b0010, mk(20'h5F000), 0, 0, 0);
        cycle(4'b0010, mk(20'h5F000), 1, 0, 0);
        chk("full_after_pop", rq_ready[1], 1);
        cycle(4'b0010, mk(20'h5F000), 0, 0, 0);
        repeat (6) cycle(4'h0, '0, 1, 0, 0);

        // Held request stays stable while channel 3 keeps pushing.
        apply_reset();
        cycle(4'b0001, mk(20'h60000), 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1000, mk(20'h61000 + AW'(k * 16)), 0, 0, 0);
            chk("lock_valid", mri_req_valid, 1);
            chk("lock_src", mri_req_src, 0);
            chk("lock_addr", mri_req_addr, 20'h60000);
            chk("lock_tag", mri_req_tag, 0);
        end
        cycle(4'h0, '0, 1, 0, 0);
        chk("lock_pop_use", tags_in_use, 1);
        chk("lock_next_src", mri_req_src, 3);
        chk("lock_next_addr", mri_req_addr, 20'h61003);
        repeat (4) cycle(4'h0, '0, 1, 0, 0);

        // Random traffic against the model.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            int used_q [$];
            for (int i = 0; i < N; i++) av[i*AW +: AW] = AW'($urandom);
            for (int t = 0; t < MAXO; t++) if (mused[t]) used_q.push_back(t);
            if (($urandom % 10) == 0 || used_q.size() == 0) rt = int'($urandom % MAXO);
            else rt = used_q[$urandom % used_q.size()];
            cycle(N'($urandom), av, ($urandom % 4) != 0, ($urandom % 3) == 0, rt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
